ring_osc_freq_meter: RTL and testbench

Gated frequency counter for the on-chip ring oscillator output. It samples the free-running `osc_in` into the `clk` domain and counts its rising edges over a fixed window of `GATE_LEN` clock cycles. It then presents a registered count with a one-cycle `done` strobe. It sits on the receive side of the ring-oscillator tile and turns the raw oscillation into a number that can be driven onto the output pins.

---
 rtl/ring_osc_freq_meter.sv | 113 +++++++++++
 tb/tb_ring_osc_freq_meter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : ring_osc_freq_meter
// Brief    : Gated rising-edge counter for the ring-oscillator output.
// Revision : 1.0 - initial release
// ============================================================================
module ring_osc_freq_meter #(
    parameter int GATE_LEN = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int                 c_WIN_W    = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LOAD = c_WIN_W'(GATE_LEN - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_GATE = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic               r_s1, r_s2, r_s3;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_win_ovf;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_rise;
    logic               w_load;
    logic               w_win_last;
    logic               w_edge_sat;
    logic [CNT_W-1:0]   w_edge_next;
    logic               w_ovf_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= osc_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)      w_state_next = c_ST_GATE;
            c_ST_GATE: if (w_win_last) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = continuous ? c_ST_GATE : c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    assign w_load      = ((r_state == c_ST_IDLE) && start) ||
                         ((r_state == c_ST_DONE) && continuous);
    assign w_win_last  = (r_win_cnt == '0);
    assign w_edge_sat  = (r_edge_cnt == c_CNT_MAX);
    assign w_edge_next = (w_rise && !w_edge_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_ovf_next  = r_win_ovf | (w_rise & w_edge_sat);

    // The result is captured on the last GATE cycle (including its rise) so
    // that it is already visible while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_load) begin
            r_win_cnt  <= c_WIN_LOAD;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end else if (r_state == c_ST_GATE) begin
            r_edge_cnt <= w_edge_next;
            r_win_ovf  <= w_ovf_next;
            if (w_win_last) begin
                r_count    <= w_edge_next;
                r_overflow <= w_ovf_next;
            end else begin
                r_win_cnt  <= r_win_cnt - c_WIN_W'(1);
            end
        end
    end

    assign busy     = (r_state == c_ST_GATE);
    assign done     = (r_state == c_ST_DONE);
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_osc_freq_meter
// Brief    : Scoreboard bench: 16-bit meter (dut_a) and 4-bit saturating meter (dut_b).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_osc_freq_meter;

    localparam int c_GATE = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc_in = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        continuous = 1'b0;
    logic        cont_b = 1'b0;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt_a = 0;
    int done_cnt_a = 0;
    int last_done_a = 0;
    bit prev_done_a = 0;
    bit osc_run = 0;
    int ph = 0;

    logic [16:0] q_a[$];
    logic [4:0]  q_b[$];
    int          done_times_a[$];

    ring_osc_freq_meter #(.GATE_LEN(c_GATE), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start_a),
        .continuous(continuous), .busy(busy_a), .done(done_a),
        .count(count_a), .overflow(ovf_a)
    );

    ring_osc_freq_meter #(.GATE_LEN(c_GATE), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start_b),
        .continuous(cont_b), .busy(busy_b), .done(done_b),
        .count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (osc_run) begin
            ph = ph + 1;
            osc_in = ((ph / 2) % 2) == 1;
        end else begin
            osc_in = 1'b0;
        end
    end

    // Scoreboard: every done pulse pops and checks the oldest expected result.
    always @(negedge clk) begin
        if (busy_a) busy_cnt_a = busy_cnt_a + 1;
        if (done_a) begin
            checks = checks + 1;
            if (prev_done_a) begin
                errors = errors + 1;
                $display("FAIL done_back_to_back: done high two cycles at cyc %0d, required single pulse", cyc);
            end
            done_cnt_a = done_cnt_a + 1;
            last_done_a = cyc;
            done_times_a.push_back(cyc);
            checks = checks + 1;
            if (q_a.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done_a: done at cyc %0d count %0d, required no done", cyc, count_a);
            end else begin
                logic [16:0] exp_a;
                exp_a = q_a.pop_front();
                if ({ovf_a, count_a} !== exp_a) begin
                    errors = errors + 1;
                    $display("FAIL result_a: got count %0d ovf %0b, required count %0d ovf %0b",
                             count_a, ovf_a, exp_a[15:0], exp_a[16]);
                end
            end
        end
        if (done_b) begin
            checks = checks + 1;
            if (q_b.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done_b: done at cyc %0d, required no done", cyc);
            end else begin
                logic [4:0] exp_b;
                exp_b = q_b.pop_front();
                if ({ovf_b, count_b} !== exp_b) begin
                    errors = errors + 1;
                    $display("FAIL result_b: got count %0d ovf %0b, required count %0d ovf %0b",
                             count_b, ovf_b, exp_b[3:0], exp_b[4]);
                end
            end
        end
        prev_done_a = done_a;
    end

    task automatic pulse_start_a(output int t);
        @(posedge clk); #1;
        start_a = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        checks = checks + 1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_timeout: %0d/%0d results pending, required 0", name, q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks = checks + 2;
        if ({busy_a, done_a, ovf_a, count_a} !== 19'd0) begin
            errors = errors + 1;
            $display("FAIL reset_a: busy %0b done %0b ovf %0b count %0d, required all 0", busy_a, done_a, ovf_a, count_a);
        end
        if ({busy_b, done_b, ovf_b, count_b} !== 7'd0) begin
            errors = errors + 1;
            $display("FAIL reset_b: busy %0b done %0b ovf %0b count %0d, required all 0", busy_b, done_b, ovf_b, count_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (busy_a !== 1'b0 || done_cnt_a != 0) begin
            errors = errors + 1;
            $display("FAIL idle_after_reset: busy %0b dones %0d, required 0 0", busy_a, done_cnt_a);
        end
    endtask

    task automatic test_nominal();
        int t;
        osc_run = 1;
        repeat (10) @(posedge clk);
        busy_cnt_a = 0;
        q_a.push_back({1'b0, 16'd25});
        pulse_start_a(t);
        wait_drain("nominal", 200);
        checks = checks + 2;
        if (last_done_a != t + c_GATE + 1) begin
            errors = errors + 1;
            $display("FAIL nominal_done_cycle: got %0d, required %0d", last_done_a, t + c_GATE + 1);
        end
        if (busy_cnt_a != c_GATE) begin
            errors = errors + 1;
            $display("FAIL nominal_busy_len: got %0d, required %0d", busy_cnt_a, c_GATE);
        end
    endtask

    task automatic test_static();
        int t;
        int d0;
        osc_run = 0;
        repeat (10) @(posedge clk);
        d0 = done_cnt_a;
        q_a.push_back({1'b0, 16'd0});
        pulse_start_a(t);
        wait_drain("static", 200);
        repeat (20) @(negedge clk);
        checks = checks + 1;
        if (done_cnt_a - d0 != 1) begin
            errors = errors + 1;
            $display("FAIL static_done_pulses: got %0d, required 1", done_cnt_a - d0);
        end
    endtask

    task automatic test_saturation();
        osc_run = 1;
        repeat (10) @(posedge clk);
        q_b.push_back({1'b1, 4'd15});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_drain("saturation", 200);
        osc_run = 0;
        repeat (10) @(posedge clk);
        q_b.push_back({1'b0, 4'd0});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_drain("saturation_clear", 200);
    endtask

    task automatic test_continuous();
        int t;
        osc_run = 1;
        repeat (10) @(posedge clk);
        done_times_a.delete();
        for (int i = 0; i < 4; i++) q_a.push_back({1'b0, 16'd25});
        continuous = 1'b1;
        pulse_start_a(t);
        for (int i = 0; i < 400 && done_times_a.size() < 3; i++) @(negedge clk);
        repeat (50) @(posedge clk);
        #1 continuous = 1'b0;
        wait_drain("continuous", 200);
        checks = checks + 1;
        if (done_times_a.size() != 4) begin
            errors = errors + 1;
            $display("FAIL cont_done_count: got %0d, required 4", done_times_a.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks = checks + 1;
                if (done_times_a[i] - done_times_a[i-1] != c_GATE + 1) begin
                    errors = errors + 1;
                    $display("FAIL cont_period_%0d: got %0d, required %0d", i,
                             done_times_a[i] - done_times_a[i-1], c_GATE + 1);
                end
            end
        end
        busy_cnt_a = 0;
        repeat (30) @(negedge clk);
        checks = checks + 1;
        if (busy_cnt_a != 0) begin
            errors = errors + 1;
            $display("FAIL cont_stop_busy: busy cycles %0d, required 0", busy_cnt_a);
        end
    endtask

    task automatic test_start_while_busy();
        int t;
        int d0;
        osc_run = 1;
        d0 = done_cnt_a;
        q_a.push_back({1'b0, 16'd25});
        pulse_start_a(t);
        repeat (48) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_drain("start_busy", 200);
        checks = checks + 1;
        if (last_done_a != t + c_GATE + 1) begin
            errors = errors + 1;
            $display("FAIL start_busy_done_cycle: got %0d, required %0d", last_done_a, t + c_GATE + 1);
        end
        repeat (150) @(negedge clk);
        checks = checks + 1;
        if (done_cnt_a - d0 != 1 || busy_a !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL start_busy_single: dones %0d busy %0b, required 1 0", done_cnt_a - d0, busy_a);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int d0;
        osc_run = 1;
        pulse_start_a(t);
        repeat (58) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        d0 = done_cnt_a;
        @(negedge clk);
        checks = checks + 1;
        if (busy_a !== 1'b0 || count_a !== 16'd0 || ovf_a !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_outputs: busy %0b count %0d ovf %0b, required 0 0 0", busy_a, count_a, ovf_a);
        end
        repeat (150) @(negedge clk);
        checks = checks + 1;
        if (done_cnt_a != d0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_no_done: dones %0d, required 0", done_cnt_a - d0);
        end
        q_a.push_back({1'b0, 16'd25});
        pulse_start_a(t);
        wait_drain("reset_mid_restart", 200);
        checks = checks + 1;
        if (last_done_a != t + c_GATE + 1) begin
            errors = errors + 1;
            $display("FAIL reset_mid_done_cycle: got %0d, required %0d", last_done_a, t + c_GATE + 1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_static();
        test_saturation();
        test_continuous();
        test_start_while_busy();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
